// File: rtl/uart_rx_if.sv
// Receive-side bus between the UART receiver and the core: serial line in,
// received byte out through a valid/rd handshake, plus status flags.
interface uart_rx_if;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  // Core/board side: drives the line and the acknowledge.
  modport master (
    output rx,
    output rd,
    input  data,
    input  valid,
    input  ferr,
    input  ovr,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    input  rd,
    output data,
    output valid,
    output ferr,
    output ovr,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Bit timing is re-aligned on every start-bit
// falling edge and each bit is sampled at mid-period. Completed bytes are
// handed to the core through valid/rd; framing errors and overruns are flagged.
module uart_rx #(
  parameter int unsigned BAUDRATE = 104
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned        CNT_W    = $clog2(BAUDRATE);
  localparam logic [CNT_W-1:0]   TICK_VAL = CNT_W'(BAUDRATE - 1);
  // Preload so the first tick falls BAUDRATE/2 edges after the start edge.
  localparam logic [CNT_W-1:0]   PRELOAD  = CNT_W'(BAUDRATE - BAUDRATE / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHI
  } state_t;

  state_t           state;
  logic             rx_s1;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             load_p;
  logic             ferr_p;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             busy_q;

  assign tick = (cnt == TICK_VAL);

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rxs   <= rx_s1;
    end
  end

  // Bit-period counter: parked in IDLE, preloaded on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= rxs ? '0 : PRELOAD;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

  // Frame FSM: start check, eight data bits, stop check, break recovery.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      load_p  <= 1'b0;
      ferr_p  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      load_p <= 1'b0;
      ferr_p <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state  <= S_START;
            busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (rxs) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rxs) begin
              load_p <= 1'b1;
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              ferr_p <= 1'b1;
              state  <= S_WAITHI;
            end
          end
        end
        S_WAITHI: begin
          if (rxs) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Output register: byte hand-off, valid/rd handshake, overrun, ferr pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_p;
      if (load_p) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
        ovr_q   <= valid_q & ~bus.rd;
      end else if (bus.rd) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ferr  = ferr_q;
  assign bus.ovr   = ovr_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at BAUDRATE=104. Expected
// outputs come from a byte-level model of the receive handshake.
module tb_uart_rx;

  localparam int B = 104;
  // Relative edge (from the edge before rx is driven) at which valid/ferr
  // appear: 1 edge to first sync sample, 2 sync stages, B/2 + 9*B to the
  // stop sample, then one more edge.
  localparam int DONE_REL = 1 + 2 + B / 2 + 9 * B + 1;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_ovr;

  uart_rx_if bus ();

  uart_rx #(.BAUDRATE(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one 10-bit frame; optionally pulse rd at a given relative edge or
  // abort with a reset at a given relative edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rd_at, input int abort_at,
                            output int rise_rel, output int ferr_rel,
                            output int ferr_cnt, output bit aborted);
    int         start;
    logic       vprev;
    logic [9:0] fr;
    fr       = {stop_bit, b, 1'b0};
    start    = cyc;
    vprev    = bus.valid;
    rise_rel = -1;
    ferr_rel = -1;
    ferr_cnt = 0;
    aborted  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.rx = fr[k];
      for (int j = 0; j < B; j++) begin
        int rel;
        rel    = cyc - start;
        bus.rd = (rel == rd_at - 1);
        if (rel == abort_at - 1) begin
          rst    = 1'b1;
          bus.rx = 1'b1;
        end
        step();
        bus.rd = 1'b0;
        if (rst) begin
          rst     = 1'b0;
          aborted = 1'b1;
          return;
        end
        if (bus.valid && !vprev && rise_rel < 0) rise_rel = rel + 1;
        vprev = bus.valid;
        if (bus.ferr) begin
          ferr_cnt = ferr_cnt + 1;
          if (ferr_rel < 0) ferr_rel = rel + 1;
        end
      end
    end
  endtask

  // Hold the line at a level for n cycles, watching ferr and busy.
  task automatic hold(input logic lvl, input int n, output int ferr_cnt, output bit busy_seen);
    ferr_cnt  = 0;
    busy_seen = 1'b0;
    bus.rx    = lvl;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.ferr) ferr_cnt = ferr_cnt + 1;
      if (bus.busy) busy_seen = 1'b1;
    end
  endtask

  task automatic rd_pulse();
    bus.rd = 1'b1;
    step();
    bus.rd    = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Model: a good frame delivers its byte; overrun if the previous byte was
  // still waiting and not acknowledged on the completion edge.
  task automatic model_byte(input logic [7:0] b, input bit rd_on_done);
    exp_ovr   = exp_valid && !rd_on_done;
    exp_valid = 1'b1;
    exp_data  = b;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  32'(bus.data),  32'(exp_data));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(exp_valid));
    chk({tag, ".ovr"},   32'(bus.ovr),   32'(exp_ovr));
  endtask

  initial begin
    int         rise;
    int         fpos;
    int         fcnt;
    int         fcnt2;
    bit         busy_seen;
    bit         ab;
    logic [7:0] rb;
    bit         rdc;

    total  = 0;
    passed = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.rx = 1'b1;
    bus.rd = 1'b0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;

    repeat (3) step();
    rst = 1'b0;
    chk("reset.data",  32'(bus.data),  32'h00);
    chk("reset.valid", 32'(bus.valid), 32'h0);
    chk("reset.ferr",  32'(bus.ferr),  32'h0);
    chk("reset.ovr",   32'(bus.ovr),   32'h0);
    chk("reset.busy",  32'(bus.busy),  32'h0);
    repeat (5) step();

    // Basic frame and valid timing.
    send_frame(8'h55, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h55, 1'b0);
    chk("f55.rise", 32'(rise), 32'(DONE_REL));
    chk_model("f55");
    chk("f55.ferr_cnt", 32'(fcnt), 32'h0);
    chk("f55.busy", 32'(bus.busy), 32'h0);
    rd_pulse();
    chk_model("f55.rd");

    // Glitch shorter than half a bit.
    hold(1'b0, 20, fcnt, busy_seen);
    chk("glitch.busy_seen", 32'(busy_seen), 32'h1);
    hold(1'b1, B, fcnt2, busy_seen);
    chk("glitch.ferr", 32'(fcnt + fcnt2), 32'h0);
    chk("glitch.busy", 32'(bus.busy), 32'h0);
    chk_model("glitch");
    send_frame(8'hA3, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'hA3, 1'b0);
    chk_model("fA3");
    rd_pulse();

    // Framing error followed by a break.
    send_frame(8'h0F, 1'b0, -1, -1, rise, fpos, fcnt, ab);
    chk("ferr.pos", 32'(fpos), 32'(DONE_REL));
    hold(1'b0, 3 * B, fcnt2, busy_seen);
    chk("ferr.count", 32'(fcnt + fcnt2), 32'h1);
    hold(1'b1, 5, fcnt2, busy_seen);
    chk("ferr.busy", 32'(bus.busy), 32'h0);
    chk_model("ferr");
    send_frame(8'h81, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h81, 1'b0);
    chk_model("f81");
    chk("f81.ferr_cnt", 32'(fcnt), 32'h0);
    rd_pulse();

    // Overrun, back-to-back frames.
    send_frame(8'h12, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h12, 1'b0);
    send_frame(8'h34, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h34, 1'b0);
    chk_model("ovr");
    chk("ovr.flag", 32'(bus.ovr), 32'h1);
    rd_pulse();
    chk_model("ovr.rd");

    // rd coincident with completion.
    send_frame(8'h12, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h12, 1'b0);
    send_frame(8'h34, 1'b1, DONE_REL, -1, rise, fpos, fcnt, ab);
    model_byte(8'h34, 1'b1);
    chk_model("rdc");
    chk("rdc.ovr", 32'(bus.ovr), 32'h0);

    // Reset during data bit 4.
    send_frame(8'hC6, 1'b1, -1, 5 * B + B / 2, rise, fpos, fcnt, ab);
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    chk("rst.aborted", 32'(ab), 32'h1);
    chk_model("rst");
    chk("rst.ferr", 32'(bus.ferr), 32'h0);
    chk("rst.busy", 32'(bus.busy), 32'h0);
    hold(1'b1, 2 * B, fcnt, busy_seen);
    chk("rst.idle_busy", 32'(busy_seen), 32'h0);
    send_frame(8'h7E, 1'b1, -1, -1, rise, fpos, fcnt, ab);
    model_byte(8'h7E, 1'b0);
    chk_model("f7E");
    chk("f7E.ferr_cnt", 32'(fcnt), 32'h0);

    // Randomized back-to-back traffic with random acknowledges.
    for (int n = 0; n < 6; n++) begin
      rb  = 8'($urandom);
      rdc = 1'($urandom_range(0, 1));
      send_frame(rb, 1'b1, rdc ? DONE_REL : -1, -1, rise, fpos, fcnt, ab);
      model_byte(rb, rdc);
      chk_model("rand");
      chk("rand.ferr_cnt", 32'(fcnt), 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        rd_pulse();
        chk_model("rand.rd");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
